// File: rtl/poly_encode12.sv
// Packs a stream of 12-bit coefficients, up to two per cycle, into 3-byte words.
// A one-entry pending register pairs coefficients that arrive in odd groupings.
module poly_encode12 #(
    parameter int N_COEFF = 256,
    parameter int Q       = 3329
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    input  logic [11:0] i_first,
    input  logic [11:0] i_second,
    input  logic        i_first_en,
    input  logic        i_second_en,
    output logic [23:0] o_word,
    output logic [6:0]  o_addr,
    output logic        o_valid,
    output logic        o_err,
    output logic        o_done
);

    localparam int CNT_W = $clog2(N_COEFF + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_COEFF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_COEFF - 1);
    localparam logic [11:0]      Q_L      = 12'(Q);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t           state, state_next;
    logic [11:0]      pend, pend_next;
    logic             pend_v, pend_v_next;
    logic [CNT_W-1:0] coeff_cnt, cnt_next;
    logic [6:0]       word_cnt;

    logic [11:0] c_a, c_b;
    logic [1:0]  n_pres, n_acc;
    logic [11:0] e0, e1;
    logic        emit, err_hit, start_clear;

    function automatic logic [23:0] pack(input logic [11:0] c0, input logic [11:0] c1);
        return {c0[7:0], c1[3:0], c0[11:8], c1[11:4]};
    endfunction

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        start_clear = 1'b0;
        c_a         = i_first;
        c_b         = i_second;
        n_pres      = 2'd0;
        n_acc       = 2'd0;
        emit        = 1'b0;
        e0          = pend;
        e1          = i_first;
        pend_next   = pend;
        pend_v_next = pend_v;

        // Compact the presented coefficients so c_a is always the earliest one.
        if (i_first_en && i_second_en) begin
            n_pres = 2'd2;
        end else if (i_first_en) begin
            n_pres = 2'd1;
        end else if (i_second_en) begin
            n_pres = 2'd1;
            c_a    = i_second;
        end

        if (state == S_COLLECT) begin
            if (coeff_cnt >= CNT_FULL)
                n_acc = 2'd0;
            else if (coeff_cnt == CNT_LAST && n_pres == 2'd2)
                n_acc = 2'd1;
            else
                n_acc = n_pres;
        end

        case (n_acc)
            2'd2: begin
                emit = 1'b1;
                if (pend_v) begin
                    e0        = pend;
                    e1        = c_a;
                    pend_next = c_b;
                end else begin
                    e0 = c_a;
                    e1 = c_b;
                end
            end
            2'd1: begin
                if (pend_v) begin
                    emit        = 1'b1;
                    e0          = pend;
                    e1          = c_a;
                    pend_v_next = 1'b0;
                end else begin
                    pend_next   = c_a;
                    pend_v_next = 1'b1;
                end
            end
            default: ;
        endcase

        err_hit  = ((n_acc != 2'd0) && (c_a >= Q_L)) || ((n_acc == 2'd2) && (c_b >= Q_L));
        cnt_next = coeff_cnt + CNT_W'(n_acc);

        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_next  = S_COLLECT;
                    start_clear = 1'b1;
                end
            end
            S_COLLECT: begin
                if (cnt_next == CNT_FULL)
                    state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pend      <= '0;
            pend_v    <= 1'b0;
            coeff_cnt <= '0;
            word_cnt  <= '0;
            o_word    <= '0;
            o_addr    <= '0;
            o_valid   <= 1'b0;
            o_err     <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            if (start_clear) begin
                pend      <= '0;
                pend_v    <= 1'b0;
                coeff_cnt <= '0;
                word_cnt  <= '0;
                o_err     <= 1'b0;
            end else begin
                pend      <= pend_next;
                pend_v    <= pend_v_next;
                coeff_cnt <= cnt_next;
                word_cnt  <= word_cnt + 7'(emit);
                o_err     <= o_err | err_hit;
            end
            o_valid <= emit;
            if (emit) begin
                o_word <= pack(e0, e1);
                o_addr <= word_cnt;
            end
            o_done <= (state == S_COLLECT) && (state_next == S_DONE);
        end
    end

endmodule
